// File: rtl/reg_bank_dumper_pkg.sv
// Shared definitions for the register bank dumper: FSM state encoding and
// byte-serialization sizing helpers.
package reg_bank_dumper_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_SEND = 2'd2,
        ST_DONE = 2'd3
    } dump_state_t;

    localparam int DEFAULT_DATA_WIDTH = 32;
    localparam int BYTES_PER_WORD     = DEFAULT_DATA_WIDTH / 8;
    localparam int BYTE_CNT_W         = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;

    // Byte-counter width for an arbitrary word width (never narrower than 1 bit).
    function automatic int byte_cnt_width(input int data_width);
        int bpw;
        bpw = data_width / 8;
        return (bpw > 1) ? $clog2(bpw) : 1;
    endfunction

endpackage

// File: rtl/reg_bank_dumper_serializer.sv
// Word-to-byte serializer: captures one word on load and presents it MSB
// byte first over a valid/ready handshake. o_last flags the transfer of the
// final byte so the sequencer can react on the same edge.
module word_byte_serializer
    import reg_bank_dumper_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic                  i_load,
    input  logic [DATA_WIDTH-1:0] i_word,
    input  logic                  i_ready,
    output logic [7:0]            o_byte,
    output logic                  o_valid,
    output logic                  o_last
);

    localparam int BPW   = DATA_WIDTH / 8;
    localparam int CNT_W = byte_cnt_width(DATA_WIDTH);

    logic [DATA_WIDTH-1:0] shreg;
    logic [CNT_W-1:0]      byte_cnt;
    logic                  xfer;

    assign xfer   = o_valid && i_ready;
    assign o_byte = shreg[DATA_WIDTH-1 -: 8];
    assign o_last = xfer && (byte_cnt == CNT_W'(BPW - 1));

    // Snapshot the word on load, then shift one byte out per accepted transfer.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            shreg    <= '0;
            byte_cnt <= '0;
            o_valid  <= 1'b0;
        end else if (i_load) begin
            shreg    <= i_word;
            byte_cnt <= '0;
            o_valid  <= 1'b1;
        end else if (xfer) begin
            shreg <= shreg << 8;
            if (o_last) begin
                byte_cnt <= '0;
                o_valid  <= 1'b0;
            end else begin
                byte_cnt <= byte_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/reg_bank_dumper.sv
// Register bank dumper: walks the bank read port over addresses
// 0..N_REGS-1 and streams every word MSB byte first to the debug TX path.
module reg_bank_dumper
    import reg_bank_dumper_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int N_REGS     = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic                  i_start,
    output logic [ADDR_WIDTH-1:0] o_rd_addr,
    input  logic [DATA_WIDTH-1:0] i_rd_data,
    output logic [7:0]            o_tx_data,
    output logic                  o_tx_valid,
    input  logic                  i_tx_ready,
    output logic                  o_busy,
    output logic                  o_done
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(N_REGS - 1);

    dump_state_t state;
    logic        load;
    logic        word_sent;

    // The serializer captures i_rd_data during the single LOAD cycle only.
    assign load = (state == ST_LOAD);

    word_byte_serializer #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_serializer (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .i_load  (load),
        .i_word  (i_rd_data),
        .i_ready (i_tx_ready),
        .o_byte  (o_tx_data),
        .o_valid (o_tx_valid),
        .o_last  (word_sent)
    );

    // Dump sequencer: owns the address walk and the busy/done indications.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state     <= ST_IDLE;
            o_rd_addr <= '0;
            o_busy    <= 1'b0;
            o_done    <= 1'b0;
        end else begin
            o_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    o_rd_addr <= '0;
                    if (i_start) begin
                        state  <= ST_LOAD;
                        o_busy <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    state <= ST_SEND;
                end
                ST_SEND: begin
                    if (word_sent) begin
                        if (o_rd_addr == LAST_ADDR) begin
                            state  <= ST_DONE;
                            o_busy <= 1'b0;
                            o_done <= 1'b1;
                        end else begin
                            o_rd_addr <= o_rd_addr + 1'b1;
                            state     <= ST_LOAD;
                        end
                    end
                end
                ST_DONE: begin
                    // A start request here is deliberately dropped.
                    state     <= ST_IDLE;
                    o_rd_addr <= '0;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reg_bank_dumper.sv
// Self-checking bench for reg_bank_dumper: bank model, byte scoreboard,
// per-cycle busy/done/hold checks and scenario tasks.
module tb_reg_bank_dumper;

    localparam int DW     = 32;
    localparam int NR     = 32;
    localparam int AW     = 5;
    localparam int NBYTES = NR * DW / 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          tx_ready;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic [7:0]    tx_data;
    logic          tx_valid;
    logic          busy;
    logic          done;

    logic [DW-1:0] bank [NR];
    logic [7:0]    q [$];

    int n_checks = 0;
    int n_fail   = 0;

    assign rd_data = bank[rd_addr];

    always #5 clk = ~clk;

    reg_bank_dumper #(
        .DATA_WIDTH(DW),
        .N_REGS    (NR),
        .ADDR_WIDTH(AW)
    ) dut (
        .i_clock   (clk),
        .i_reset   (rst),
        .i_start   (start),
        .o_rd_addr (rd_addr),
        .i_rd_data (rd_data),
        .o_tx_data (tx_data),
        .o_tx_valid(tx_valid),
        .i_tx_ready(tx_ready),
        .o_busy    (busy),
        .o_done    (done)
    );

    // Runs one dump from an i_start pulse. Must be entered #1 after a posedge.
    task automatic run_dump(input bit rnd_ready, input bit do_stall, input bit do_snap,
                            input bit extra_start, input int reset_at,
                            output int nbytes, output int ndone, output int first_vld_cyc,
                            output int done_cyc, output int nstall);
        int       last_pop_cyc;
        int       stall_left;
        bit       stall_done;
        bit       prev_hold;
        bit       finished;
        bit       xfer;
        logic     exp_busy;
        logic     exp_done;
        logic [7:0] prev_data;
        logic [7:0] exp_byte;
        logic [DW-1:0] w;
        nbytes = 0; ndone = 0; first_vld_cyc = 0; done_cyc = 0; nstall = 0;
        last_pop_cyc = 0; stall_left = 0; stall_done = 0; prev_hold = 0;
        finished = 0; prev_data = 8'h00;
        q.delete();
        for (int k = 0; k < NR; k++) begin
            w = bank[k];
            for (int b = 0; b < DW / 8; b++) begin
                q.push_back(w[DW-1-8*b -: 8]);
            end
        end
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int cyc = 1; cyc < 3000; cyc++) begin
            start = extra_start && (cyc == 10 || cyc == 161);
            rst   = (reset_at != 0) && (cyc == reset_at);
            if (do_snap && cyc == 17) begin
                n_checks++;
                if (rd_addr !== 5'd3 || tx_valid !== 1'b1 || tx_data !== 8'hA0)
                    $display("FAIL snap_timing: addr=%0d valid=%b data=%h, required addr=3 valid=1 data=a0",
                             rd_addr, tx_valid, tx_data);
                    else ;
                if (rd_addr !== 5'd3 || tx_valid !== 1'b1 || tx_data !== 8'hA0) n_fail++;
                bank[3] = 32'hDEADBEEF;
            end
            if (do_stall && !stall_done && stall_left == 0 && nbytes == 22) stall_left = 7;
            if (stall_left > 0)  tx_ready = 1'b0;
            else if (rnd_ready)  tx_ready = ($urandom_range(0, 3) != 0);
            else                 tx_ready = 1'b1;

            @(negedge clk);
            if (stall_left > 0) begin
                n_checks++;
                nstall++;
                if (tx_valid !== 1'b1 || tx_data !== 8'hC0) begin
                    n_fail++;
                    $display("FAIL stall_hold: cyc=%0d valid=%b data=%h, required valid=1 data=c0",
                             cyc, tx_valid, tx_data);
                end
                stall_left--;
                if (stall_left == 0) stall_done = 1;
            end
            exp_busy = (last_pop_cyc == 0) || (cyc <= last_pop_cyc);
            exp_done = (last_pop_cyc != 0) && (cyc == last_pop_cyc + 1);
            n_checks++;
            if (busy !== exp_busy) begin
                n_fail++;
                $display("FAIL busy: cyc=%0d got %b, required %b", cyc, busy, exp_busy);
            end
            n_checks++;
            if (done !== exp_done) begin
                n_fail++;
                $display("FAIL done: cyc=%0d got %b, required %b", cyc, done, exp_done);
            end
            if (done === 1'b1) begin
                ndone++;
                if (done_cyc == 0) done_cyc = cyc;
            end
            if (prev_hold) begin
                n_checks++;
                if (tx_valid !== 1'b1 || tx_data !== prev_data) begin
                    n_fail++;
                    $display("FAIL hold: cyc=%0d valid=%b data=%h, required valid=1 data=%h",
                             cyc, tx_valid, tx_data, prev_data);
                end
            end
            if (tx_valid === 1'b1 && first_vld_cyc == 0) first_vld_cyc = cyc;
            xfer      = (tx_valid === 1'b1) && tx_ready && !rst;
            prev_hold = (tx_valid === 1'b1) && !tx_ready && !rst;
            prev_data = tx_data;
            if (xfer) begin
                n_checks++;
                if (q.size() == 0) begin
                    n_fail++;
                    $display("FAIL extra_byte: cyc=%0d got %h, required no transfer", cyc, tx_data);
                end else begin
                    exp_byte = q.pop_front();
                    if (tx_data !== exp_byte) begin
                        n_fail++;
                        $display("FAIL byte[%0d]: got %h, required %h", nbytes, tx_data, exp_byte);
                    end
                    nbytes++;
                    if (q.size() == 0) last_pop_cyc = cyc;
                end
            end
            @(posedge clk); #1;
            if (rst) begin
                rst = 1'b0;
                n_checks++;
                if (tx_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 ||
                    tx_data !== 8'h00 || rd_addr !== '0) begin
                    n_fail++;
                    $display("FAIL reset_mid_outputs: valid=%b busy=%b done=%b data=%h addr=%0d, required all 0",
                             tx_valid, busy, done, tx_data, rd_addr);
                end
                q.delete();
                finished = 1;
                break;
            end
            if (last_pop_cyc != 0 && cyc > last_pop_cyc + 20) begin
                finished = 1;
                break;
            end
        end
        start = 1'b0;
        if (!finished) begin
            n_checks++;
            n_fail++;
            $display("FAIL timeout: dump did not complete, %0d bytes seen, required %0d", nbytes, NBYTES);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; tx_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (tx_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || tx_data !== 8'h00 || rd_addr !== '0) begin
            n_fail++;
            $display("FAIL reset_state: valid=%b busy=%b done=%b data=%h addr=%0d, required all 0",
                     tx_valid, busy, done, tx_data, rd_addr);
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        int nb, nd, fv, dc, ns;
        run_dump(0, 0, 0, 0, 0, nb, nd, fv, dc, ns);
        n_checks++;
        if (nb != NBYTES) begin n_fail++; $display("FAIL basic_count: got %0d, required %0d", nb, NBYTES); end
        n_checks++;
        if (nd != 1) begin n_fail++; $display("FAIL basic_done_pulses: got %0d, required 1", nd); end
        n_checks++;
        if (dc != 161) begin n_fail++; $display("FAIL basic_done_cycle: got %0d, required 161", dc); end
        n_checks++;
        if (fv != 2) begin n_fail++; $display("FAIL basic_first_valid: got %0d, required 2", fv); end
    endtask

    task automatic test_backpressure();
        int nb, nd, fv, dc, ns;
        run_dump(1, 1, 0, 0, 0, nb, nd, fv, dc, ns);
        n_checks++;
        if (nb != NBYTES) begin n_fail++; $display("FAIL bp_count: got %0d, required %0d", nb, NBYTES); end
        n_checks++;
        if (nd != 1) begin n_fail++; $display("FAIL bp_done_pulses: got %0d, required 1", nd); end
        n_checks++;
        if (ns != 7) begin n_fail++; $display("FAIL bp_stall_cycles: got %0d, required 7", ns); end
    endtask

    task automatic test_start_while_busy();
        int nb, nd, fv, dc, ns;
        run_dump(0, 0, 0, 1, 0, nb, nd, fv, dc, ns);
        n_checks++;
        if (nb != NBYTES) begin n_fail++; $display("FAIL swb_count: got %0d, required %0d", nb, NBYTES); end
        n_checks++;
        if (nd != 1) begin n_fail++; $display("FAIL swb_done_pulses: got %0d, required 1", nd); end
        n_checks++;
        if (dc != 161) begin n_fail++; $display("FAIL swb_done_cycle: got %0d, required 161", dc); end
    endtask

    task automatic test_snapshot();
        int nb, nd, fv, dc, ns;
        run_dump(0, 0, 1, 0, 0, nb, nd, fv, dc, ns);
        n_checks++;
        if (nb != NBYTES) begin n_fail++; $display("FAIL snap_count: got %0d, required %0d", nb, NBYTES); end
        run_dump(0, 0, 0, 0, 0, nb, nd, fv, dc, ns);
        n_checks++;
        if (nb != NBYTES) begin n_fail++; $display("FAIL snap2_count: got %0d, required %0d", nb, NBYTES); end
        n_checks++;
        if (nd != 1) begin n_fail++; $display("FAIL snap2_done_pulses: got %0d, required 1", nd); end
    endtask

    task automatic test_reset_mid();
        int nb, nd, fv, dc, ns;
        run_dump(0, 0, 0, 0, 40, nb, nd, fv, dc, ns);
        n_checks++;
        if (nb != 31) begin n_fail++; $display("FAIL rstmid_bytes_before: got %0d, required 31", nb); end
        n_checks++;
        if (nd != 0) begin n_fail++; $display("FAIL rstmid_done_pulses: got %0d, required 0", nd); end
        run_dump(0, 0, 0, 0, 0, nb, nd, fv, dc, ns);
        n_checks++;
        if (nb != NBYTES) begin n_fail++; $display("FAIL rstmid_redump_count: got %0d, required %0d", nb, NBYTES); end
        n_checks++;
        if (dc != 161) begin n_fail++; $display("FAIL rstmid_redump_done_cycle: got %0d, required 161", dc); end
        n_checks++;
        if (fv != 2) begin n_fail++; $display("FAIL rstmid_redump_first_valid: got %0d, required 2", fv); end
    endtask

    task automatic test_reset_quiet();
        rst = 1'b1; start = 1'b1; tx_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            n_checks++;
            if (tx_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_quiet: cyc=%0d valid=%b busy=%b done=%b, required 0 0 0",
                         i, tx_valid, busy, done);
            end
        end
        rst = 1'b0; start = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; tx_ready = 1'b0;
        for (int k = 0; k < NR; k++) bank[k] = 32'hA0B0C000 + k;
        test_reset();
        test_basic();
        test_backpressure();
        test_start_while_busy();
        test_snapshot();
        test_reset_mid();
        test_reset_quiet();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
